// File: rtl/xgmii_pkg.sv
// Shared XGMII control-character codes, frame FSM states and length arithmetic
// for the RX frame monitor.
package xgmii_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    localparam int RAW_W = 14;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } fsm_state_t;

    // Raw byte count sticks at all ones instead of wrapping on very long frames.
    function automatic logic [RAW_W-1:0] raw_sat_add(input logic [RAW_W-1:0] a,
                                                     input logic [3:0]       b);
        logic [RAW_W:0] s;
        s = {1'b0, a} + {{(RAW_W-3){1'b0}}, b};
        return s[RAW_W] ? {RAW_W{1'b1}} : s[RAW_W-1:0];
    endfunction

endpackage

// File: rtl/xgmii_ctrl_decode.sv
// Combinational decode of one 64-bit XGMII word into Start/Terminate/Error
// events that the frame monitor consumes.
module xgmii_ctrl_decode
    import xgmii_pkg::*;
(
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    output logic        start_l0,
    output logic        start_l4,
    output logic        term_valid,
    output logic [2:0]  term_lane,
    output logic [3:0]  err_cnt
);

    logic [7:0] is_term;
    logic [7:0] is_err;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign is_term[gi] = rxc[gi] && (rxd[8*gi +: 8] == XGMII_TERM);
            assign is_err[gi]  = rxc[gi] && (rxd[8*gi +: 8] == XGMII_ERROR);
        end
    endgenerate

    assign start_l0   = rxc[0] && (rxd[7:0]   == XGMII_START);
    assign start_l4   = rxc[4] && (rxd[39:32] == XGMII_START);
    assign term_valid = |is_term;

    // Scan downwards so the lowest-numbered Terminate ends up selected.
    always_comb begin
        term_lane = 3'd0;
        err_cnt   = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (is_term[i]) term_lane = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            err_cnt = err_cnt + {3'b000, is_err[i]};
        end
    end

endmodule

// File: rtl/xgmii_rx_frame_monitor.sv
// Passive XGMII RX monitor: frames by Start/Terminate, checks length and errors,
// keeps saturating statistics, link status and a stretched activity LED.
module xgmii_rx_frame_monitor
    import xgmii_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518,
    parameter int ACT_STRETCH = 15625000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      xgmii_rxd,
    input  logic [7:0]       xgmii_rxc,
    input  logic             rx_block_lock,
    input  logic             clear,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames,
    output logic [CNT_W-1:0] err_chars,
    output logic             link_up,
    output logic             act_led
);

    localparam int ACT_W = $clog2(ACT_STRETCH + 1);
    // Bounds on the raw count: raw includes 7 bytes of preamble/SFD.
    localparam logic [RAW_W-1:0] RAW_MIN = RAW_W'(MIN_LEN + 7);
    localparam logic [RAW_W-1:0] RAW_MAX = RAW_W'(MAX_LEN + 7);

    logic [7:0]       rxc_gated;
    logic             start_l0, start_l4, term_valid, has_start, word_err, len_ok;
    logic [2:0]       term_lane;
    logic [3:0]       err_cnt;
    fsm_state_t       state_reg, state_next;
    logic [RAW_W-1:0] raw_reg, raw_next, raw_sum, start_raw;
    logic             err_seen_reg, err_seen_next;
    logic             good_inc, bad_inc;
    logic [2:0][3:0]  cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];
    logic [ACT_W-1:0] act_reg;
    logic             link_reg;

    // Without block lock the word content is meaningless; masking rxc hides every event.
    assign rxc_gated = rx_block_lock ? xgmii_rxc : 8'h00;

    xgmii_ctrl_decode u_decode (
        .rxd        (xgmii_rxd),
        .rxc        (rxc_gated),
        .start_l0   (start_l0),
        .start_l4   (start_l4),
        .term_valid (term_valid),
        .term_lane  (term_lane),
        .err_cnt    (err_cnt)
    );

    assign has_start = start_l0 | start_l4;
    assign word_err  = (err_cnt != 4'd0);
    assign start_raw = start_l4 ? RAW_W'(3) : RAW_W'(7);
    assign raw_sum   = raw_sat_add(raw_reg, term_valid ? {1'b0, term_lane} : 4'd8);
    assign len_ok    = (raw_sum >= RAW_MIN) && (raw_sum <= RAW_MAX);

    always_comb begin
        state_next    = state_reg;
        raw_next      = raw_reg;
        err_seen_next = err_seen_reg;
        good_inc      = 1'b0;
        bad_inc       = 1'b0;
        if (!rx_block_lock) begin
            state_next    = ST_IDLE;
            raw_next      = '0;
            err_seen_next = 1'b0;
        end else if (has_start && term_valid) begin
            bad_inc       = 1'b1;
            state_next    = ST_IDLE;
            raw_next      = '0;
            err_seen_next = 1'b0;
        end else if (has_start) begin
            // A Start inside an open frame aborts it and begins a fresh one.
            bad_inc       = (state_reg == ST_FRAME);
            state_next    = ST_FRAME;
            raw_next      = start_raw;
            err_seen_next = word_err;
        end else if (state_reg == ST_FRAME) begin
            if (term_valid) begin
                good_inc      = !err_seen_reg && !word_err && len_ok;
                bad_inc       = !good_inc;
                state_next    = ST_IDLE;
                raw_next      = '0;
                err_seen_next = 1'b0;
            end else begin
                raw_next      = raw_sum;
                err_seen_next = err_seen_reg | word_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            raw_reg      <= '0;
            err_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            raw_reg      <= raw_next;
            err_seen_reg <= err_seen_next;
        end
    end

    assign cnt_inc = {err_cnt, {3'b000, bad_inc}, {3'b000, good_inc}};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W:0]   cnt_sum;
            assign cnt_sum = {1'b0, cnt_reg} + (CNT_W+1)'(cnt_inc[gi]);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)              cnt_reg <= '0;
                else if (clear)          cnt_reg <= '0;
                else if (cnt_sum[CNT_W]) cnt_reg <= '1;
                else                     cnt_reg <= cnt_sum[CNT_W-1:0];
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_reg  <= '0;
            link_reg <= 1'b0;
        end else begin
            link_reg <= rx_block_lock;
            if (good_inc)               act_reg <= ACT_W'(ACT_STRETCH);
            else if (act_reg != '0)     act_reg <= act_reg - 1'b1;
        end
    end

    assign good_frames = cnt_val[0];
    assign bad_frames  = cnt_val[1];
    assign err_chars   = cnt_val[2];
    assign link_up     = link_reg;
    assign act_led     = (act_reg != '0);

endmodule
